// File: rtl/lcd_spi_tx.sv
// LCD SPI serializer: one {dc, byte} word per request, mode 0, MSB first, wr_done pulse per word.
// Latency: word takes 17*CLK_DIV+2+GAP_CYCLES cycles; en_write is a level request, ignored while busy.
module lcd_spi_tx #(
  parameter int CLK_DIV    = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic       sys_clk_50MHz,
  input  logic       sys_rst_n,
  input  logic [8:0] data,
  input  logic       en_write,
  output logic       wr_done,
  output logic       cs,
  output logic       dc,
  output logic       sclk,
  output logic       mosi
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP} state_t;

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t      state, state_nx;
  logic [7:0]  div_cnt, div_cnt_nx;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic [7:0]  shreg, shreg_nx;
  logic [15:0] gap_cnt, gap_cnt_nx;
  logic        wr_done_nx, cs_nx, dc_nx, sclk_nx, mosi_nx;

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      gap_cnt <= '0;
      wr_done <= 1'b0;
      cs      <= 1'b1;
      dc      <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_cnt_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
      gap_cnt <= gap_cnt_nx;
      wr_done <= wr_done_nx;
      cs      <= cs_nx;
      dc      <= dc_nx;
      sclk    <= sclk_nx;
      mosi    <= mosi_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    div_cnt_nx = div_cnt;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    gap_cnt_nx = gap_cnt;
    wr_done_nx = 1'b0;
    cs_nx      = cs;
    dc_nx      = dc;
    sclk_nx    = sclk;
    mosi_nx    = mosi;

    case (state)
      IDLE: begin
        cs_nx   = 1'b1;
        sclk_nx = 1'b0;
        if (en_write) begin
          shreg_nx   = data[7:0];
          dc_nx      = data[8];
          mosi_nx    = data[7];
          cs_nx      = 1'b0;
          div_cnt_nx = '0;
          state_nx   = SETUP;
        end
      end

      SETUP: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nx = '0;
          bit_cnt_nx = '0;
          sclk_nx    = 1'b1;
          state_nx   = SHIFT;
        end else begin
          div_cnt_nx = div_cnt + 8'd1;
        end
      end

      SHIFT: begin
        if (div_cnt != DIV_LAST) begin
          div_cnt_nx = div_cnt + 8'd1;
        end else begin
          div_cnt_nx = '0;
          if (sclk) begin
            // falling edge: present the next bit; the last bit stays on mosi
            sclk_nx = 1'b0;
            if (bit_cnt != 3'd7) begin
              mosi_nx  = shreg[6];
              shreg_nx = {shreg[6:0], 1'b0};
            end
          end else if (bit_cnt == 3'd7) begin
            cs_nx      = 1'b1;
            wr_done_nx = 1'b1;
            state_nx   = DONE;
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
            sclk_nx    = 1'b1;
          end
        end
      end

      DONE: begin
        gap_cnt_nx = '0;
        state_nx   = (GAP_CYCLES == 0) ? IDLE : GAP;
      end

      GAP: begin
        // hold-off lets upstream synchronous ROM output settle before the next capture
        if (gap_cnt == GAP_LAST) begin
          state_nx = IDLE;
        end else begin
          gap_cnt_nx = gap_cnt + 16'd1;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule
